// File: rtl/vpg_mode_table.sv
// Runtime-programmable video timing table with handshake mode changes that
// take effect only at a frame boundary (or immediately on request).
module vpg_mode_table #(
    parameter int NUM_MODES    = 8,
    parameter int W            = 12,
    parameter int MW           = $clog2(NUM_MODES),
    parameter int DEFAULT_MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_wr,
    input  logic [MW-1:0] cfg_mode,
    input  logic [3:0]    cfg_field,
    input  logic [W-1:0]  cfg_data,
    input  logic          req_valid,
    input  logic [MW-1:0] req_mode,
    input  logic          req_immediate,
    output logic          req_ready,
    input  logic          frame_start,
    output logic [W-1:0]  h_disp,
    output logic [W-1:0]  h_fporch,
    output logic [W-1:0]  h_sync,
    output logic [W-1:0]  h_bporch,
    output logic [W-1:0]  v_disp,
    output logic [W-1:0]  v_fporch,
    output logic [W-1:0]  v_sync,
    output logic [W-1:0]  v_bporch,
    output logic [W-1:0]  h_total,
    output logic [W-1:0]  v_total,
    output logic          hs_polarity,
    output logic          vs_polarity,
    output logic          frame_interlaced,
    output logic [MW-1:0] cur_mode,
    output logic          busy,
    output logic          chg_done,
    output logic          chg_err
);

    localparam int NUM_BUILTIN = 6;
    localparam int BUILTIN [NUM_BUILTIN][8] = '{
        '{640,  16, 96,  48,  480,  10, 2, 33},
        '{720,  16, 62,  60,  480,  9,  6, 30},
        '{1024, 24, 136, 160, 768,  3,  6, 29},
        '{1280, 48, 112, 248, 1024, 1,  3, 38},
        '{1920, 88, 44,  148, 1080, 4,  5, 36},
        '{1600, 64, 192, 304, 1200, 1,  3, 46}
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_APPLY = 2'd3
    } state_t;

    function automatic logic [W-1:0] builtin_field(input int mode, input int fld);
        int m;
        m = (mode < NUM_BUILTIN) ? mode : 0;
        return W'(BUILTIN[m][fld]);
    endfunction

    function automatic logic [W-1:0] builtin_total(input int mode, input int base);
        return builtin_field(mode, base) + builtin_field(mode, base + 1) +
               builtin_field(mode, base + 2) + builtin_field(mode, base + 3);
    endfunction

    logic [W-1:0]  tbl_r   [NUM_MODES][8];
    logic [2:0]    flags_r [NUM_MODES];
    logic [W-1:0]  stg_r   [8];
    logic [2:0]    stg_flags_r;
    logic          stg_bad_r;
    logic [W-1:0]  out_r   [8];
    logic [2:0]    out_flags_r;
    logic [W-1:0]  h_total_r;
    logic [W-1:0]  v_total_r;
    logic [MW-1:0] cur_mode_r;
    logic [MW-1:0] mode_r;
    logic          ready_r;
    logic          busy_r;
    logic          chg_done_r;
    logic          chg_err_r;
    state_t        state_r;
    state_t        state_s;
    logic [MW-1:0] sel_mode_s;
    logic [MW-1:0] sel_idx_s;
    logic          sel_ok_s;
    logic          enter_check_s;
    logic [W+1:0]  h_sum_s;
    logic [W+1:0]  v_sum_s;
    logic          reject_s;

    // Timing table: built-in contents on reset, field-level runtime writes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int m = 0; m < NUM_MODES; m++) begin
                for (int f = 0; f < 8; f++) begin
                    tbl_r[m][f] <= builtin_field(m, f);
                end
                flags_r[m] <= 3'b000;
            end
        end else if (cfg_wr && (int'(cfg_mode) < NUM_MODES)) begin
            if (cfg_field < 4'd8) begin
                tbl_r[cfg_mode][cfg_field[2:0]] <= cfg_data;
            end else if (cfg_field == 4'd8) begin
                flags_r[cfg_mode] <= cfg_data[2:0];
            end
        end
    end

    // Next-state logic; sel_mode_s is the entry targeted by the pending change
    always_comb begin
        state_s    = state_r;
        sel_mode_s = mode_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    sel_mode_s = req_mode;
                    state_s    = req_immediate ? S_CHECK : S_WAIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (frame_start) begin
                    state_s = S_CHECK;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_CHECK: begin
                if (reject_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_APPLY;
                end
            end
            S_APPLY: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    assign enter_check_s = (state_s == S_CHECK) && (state_r != S_CHECK);
    assign sel_ok_s      = int'(sel_mode_s) < NUM_MODES;
    assign sel_idx_s     = sel_ok_s ? sel_mode_s : {MW{1'b0}};

    // Sums are widened so an overflowing total is detected, not wrapped
    assign h_sum_s = (W+2)'(stg_r[0]) + (W+2)'(stg_r[1]) + (W+2)'(stg_r[2]) + (W+2)'(stg_r[3]);
    assign v_sum_s = (W+2)'(stg_r[4]) + (W+2)'(stg_r[5]) + (W+2)'(stg_r[6]) + (W+2)'(stg_r[7]);
    assign reject_s = stg_bad_r ||
                      (stg_r[0] == {W{1'b0}}) || (stg_r[4] == {W{1'b0}}) ||
                      (stg_r[2] == {W{1'b0}}) || (stg_r[6] == {W{1'b0}}) ||
                      (h_sum_s[W+1:W] != 2'b00) || (v_sum_s[W+1:W] != 2'b00);

    // State and latched request mode
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            mode_r  <= MW'(DEFAULT_MODE);
        end else begin
            state_r <= state_s;
            mode_r  <= sel_mode_s;
        end
    end

    // Staging copy taken on the edge that enters CHECK, before same-edge writes land
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < 8; f++) begin
                stg_r[f] <= {W{1'b0}};
            end
            stg_flags_r <= 3'b000;
            stg_bad_r   <= 1'b0;
        end else if (enter_check_s) begin
            for (int f = 0; f < 8; f++) begin
                stg_r[f] <= tbl_r[sel_idx_s][f];
            end
            stg_flags_r <= flags_r[sel_idx_s];
            stg_bad_r   <= !sel_ok_s;
        end
    end

    // Active timing outputs and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < 8; f++) begin
                out_r[f] <= builtin_field(DEFAULT_MODE, f);
            end
            out_flags_r <= 3'b000;
            h_total_r   <= builtin_total(DEFAULT_MODE, 0);
            v_total_r   <= builtin_total(DEFAULT_MODE, 4);
            cur_mode_r  <= MW'(DEFAULT_MODE);
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            chg_done_r  <= 1'b0;
            chg_err_r   <= 1'b0;
        end else begin
            ready_r    <= (state_s == S_IDLE);
            busy_r     <= (state_s != S_IDLE);
            chg_done_r <= (state_r == S_APPLY);
            chg_err_r  <= (state_r == S_CHECK) && reject_s;
            if (state_r == S_APPLY) begin
                for (int f = 0; f < 8; f++) begin
                    out_r[f] <= stg_r[f];
                end
                out_flags_r <= stg_flags_r;
                h_total_r   <= h_sum_s[W-1:0];
                v_total_r   <= v_sum_s[W-1:0];
                cur_mode_r  <= mode_r;
            end
        end
    end

    assign h_disp           = out_r[0];
    assign h_fporch         = out_r[1];
    assign h_sync           = out_r[2];
    assign h_bporch         = out_r[3];
    assign v_disp           = out_r[4];
    assign v_fporch         = out_r[5];
    assign v_sync           = out_r[6];
    assign v_bporch         = out_r[7];
    assign hs_polarity      = out_flags_r[0];
    assign vs_polarity      = out_flags_r[1];
    assign frame_interlaced = out_flags_r[2];
    assign h_total          = h_total_r;
    assign v_total          = v_total_r;
    assign cur_mode         = cur_mode_r;
    assign req_ready        = ready_r;
    assign busy             = busy_r;
    assign chg_done         = chg_done_r;
    assign chg_err          = chg_err_r;

endmodule

// File: tb/tb_vpg_mode_table.sv
// Self-checking bench for vpg_mode_table: directed plan items plus randomized
// writes/requests compared against an array-based model of table and outputs.
module tb_vpg_mode_table;

    localparam int NM = 8;
    localparam int W  = 12;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_wr;
    logic [MW-1:0] cfg_mode;
    logic [3:0]    cfg_field;
    logic [W-1:0]  cfg_data;
    logic          req_valid;
    logic [MW-1:0] req_mode;
    logic          req_immediate;
    logic          req_ready;
    logic          frame_start;
    logic [W-1:0]  h_disp, h_fporch, h_sync, h_bporch;
    logic [W-1:0]  v_disp, v_fporch, v_sync, v_bporch;
    logic [W-1:0]  h_total, v_total;
    logic          hs_polarity, vs_polarity, frame_interlaced;
    logic [MW-1:0] cur_mode;
    logic          busy, chg_done, chg_err;

    always #5 clk = ~clk;

    vpg_mode_table #(.NUM_MODES(NM), .W(W), .MW(MW), .DEFAULT_MODE(0)) dut (
        .clk(clk), .reset(reset),
        .cfg_wr(cfg_wr), .cfg_mode(cfg_mode), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .req_valid(req_valid), .req_mode(req_mode), .req_immediate(req_immediate),
        .req_ready(req_ready), .frame_start(frame_start),
        .h_disp(h_disp), .h_fporch(h_fporch), .h_sync(h_sync), .h_bporch(h_bporch),
        .v_disp(v_disp), .v_fporch(v_fporch), .v_sync(v_sync), .v_bporch(v_bporch),
        .h_total(h_total), .v_total(v_total),
        .hs_polarity(hs_polarity), .vs_polarity(vs_polarity), .frame_interlaced(frame_interlaced),
        .cur_mode(cur_mode), .busy(busy), .chg_done(chg_done), .chg_err(chg_err)
    );

    int checks   = 0;
    int failures = 0;

    int bt [6][8] = '{
        '{640,  16, 96,  48,  480,  10, 2, 33},
        '{720,  16, 62,  60,  480,  9,  6, 30},
        '{1024, 24, 136, 160, 768,  3,  6, 29},
        '{1280, 48, 112, 248, 1024, 1,  3, 38},
        '{1920, 88, 44,  148, 1080, 4,  5, 36},
        '{1600, 64, 192, 304, 1200, 1,  3, 46}
    };
    int mtbl [NM][8];
    int mflags [NM];
    int act [8];
    int aflags;
    int acur;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int m = 0; m < NM; m++) begin
            for (int f = 0; f < 8; f++) mtbl[m][f] = bt[(m < 6) ? m : 0][f];
            mflags[m] = 0;
        end
        for (int f = 0; f < 8; f++) act[f] = mtbl[0][f];
        aflags = 0;
        acur   = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".h_disp"}, h_disp, act[0]);
        chk({tag, ".h_fporch"}, h_fporch, act[1]);
        chk({tag, ".h_sync"}, h_sync, act[2]);
        chk({tag, ".h_bporch"}, h_bporch, act[3]);
        chk({tag, ".v_disp"}, v_disp, act[4]);
        chk({tag, ".v_fporch"}, v_fporch, act[5]);
        chk({tag, ".v_sync"}, v_sync, act[6]);
        chk({tag, ".v_bporch"}, v_bporch, act[7]);
        chk({tag, ".h_total"}, h_total, act[0] + act[1] + act[2] + act[3]);
        chk({tag, ".v_total"}, v_total, act[4] + act[5] + act[6] + act[7]);
        chk({tag, ".hs_pol"}, hs_polarity, aflags % 2);
        chk({tag, ".vs_pol"}, vs_polarity, (aflags / 2) % 2);
        chk({tag, ".interlaced"}, frame_interlaced, (aflags / 4) % 2);
        chk({tag, ".cur_mode"}, cur_mode, acur);
    endtask

    task automatic wr(input int mode, input int field, input int data);
        cfg_wr = 1'b1; cfg_mode = MW'(mode); cfg_field = 4'(field); cfg_data = W'(data);
        tick();
        cfg_wr = 1'b0;
        if (mode < NM && field < 8) mtbl[mode][field] = data % 4096;
        else if (mode < NM && field == 8) mflags[mode] = data % 8;
        check_outputs("after_wr");
    endtask

    task automatic do_req(input int mode, input bit imm, input int delay, input bit fs_accept);
        int e [8];
        int ef, hs, vs;
        bit bad;
        chk("ready_pre", req_ready, 1);
        req_valid = 1'b1; req_mode = MW'(mode); req_immediate = imm; frame_start = fs_accept;
        tick();
        req_valid = 1'b0; frame_start = 1'b0;
        chk("busy_acc", busy, 1);
        chk("ready_acc", req_ready, 0);
        if (!imm) begin
            for (int i = 0; i < delay; i++) begin
                tick();
                chk("wait_done", chg_done, 0);
                chk("wait_busy", busy, 1);
            end
            check_outputs("wait");
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
        for (int f = 0; f < 8; f++) e[f] = mtbl[mode][f];
        ef = mflags[mode];
        hs = e[0] + e[1] + e[2] + e[3];
        vs = e[4] + e[5] + e[6] + e[7];
        bad = (e[0] == 0) || (e[4] == 0) || (e[2] == 0) || (e[6] == 0) || (hs > 4095) || (vs > 4095);
        chk("check_done", chg_done, 0);
        chk("check_err", chg_err, 0);
        tick();
        chk("chg_err", chg_err, bad ? 1 : 0);
        chk("done_at_check", chg_done, 0);
        if (bad) begin
            check_outputs("reject");
            chk("ready_rej", req_ready, 1);
            tick();
            chk("err_pulse_end", chg_err, 0);
        end else begin
            check_outputs("pre_apply");
            tick();
            chk("chg_done", chg_done, 1);
            for (int f = 0; f < 8; f++) act[f] = e[f];
            aflags = ef;
            acur   = mode;
            check_outputs("apply");
            chk("ready_post", req_ready, 1);
            chk("busy_post", busy, 0);
            tick();
            chk("done_pulse_end", chg_done, 0);
        end
    endtask

    initial begin
        reset = 1'b1; cfg_wr = 1'b0; cfg_mode = '0; cfg_field = '0; cfg_data = '0;
        req_valid = 1'b0; req_mode = '0; req_immediate = 1'b0; frame_start = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
        check_outputs("reset");
        chk("reset.h_total_800", h_total, 800);
        chk("reset.v_total_525", v_total, 525);
        chk("reset.ready", req_ready, 1);
        chk("reset.busy", busy, 0);
        chk("reset.done", chg_done, 0);
        chk("reset.err", chg_err, 0);

        do_req(4, 1'b0, 10, 1'b0);
        chk("plan.h_total_2200", h_total, 2200);
        chk("plan.v_total_1125", v_total, 1125);
        do_req(2, 1'b1, 0, 1'b0);
        chk("plan.h_total_1344", h_total, 1344);
        chk("plan.v_total_806", v_total, 806);

        wr(7, 2, 0);
        do_req(7, 1'b1, 0, 1'b0);
        wr(3, 3, 3000);
        do_req(3, 1'b0, 2, 1'b0);
        chk("plan.cur_after_rej", cur_mode, 2);

        wr(6, 0, 800); wr(6, 1, 40); wr(6, 2, 128); wr(6, 3, 88);
        wr(6, 4, 600); wr(6, 5, 1);  wr(6, 6, 4);   wr(6, 7, 23);
        wr(6, 8, 3);
        do_req(6, 1'b0, 3, 1'b1);
        chk("plan.h_total_1056", h_total, 1056);
        chk("plan.v_total_628", v_total, 628);
        chk("plan.hs_pol", hs_polarity, 1);
        chk("plan.vs_pol", vs_polarity, 1);
        wr(6, 0, 1000);
        wr(6, 12, 5);
        do_req(6, 1'b1, 0, 1'b0);

        // Reset while waiting for a frame boundary
        wr(0, 0, 100);
        req_valid = 1'b1; req_mode = 3'd1; req_immediate = 1'b0;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        chk("rst.busy_before", busy, 1);
        reset = 1'b1;
        tick();
        chk("rst.done", chg_done, 0);
        chk("rst.err", chg_err, 0);
        reset = 1'b0;
        model_reset();
        check_outputs("rst");
        chk("rst.ready", req_ready, 1);
        chk("rst.busy", busy, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("rst.fs_ignored_busy", busy, 0);
        tick();
        chk("rst.fs_ignored_done", chg_done, 0);
        do_req(0, 1'b1, 0, 1'b0);
        chk("rst.table_reverted", h_disp, 640);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_req($urandom_range(0, NM - 1), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 5), 1'($urandom_range(0, 1)));
            end else begin
                wr($urandom_range(0, NM - 1), $urandom_range(0, 15),
                   ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1500));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
